// File: rtl/register_file_pkg.sv
// Shared widths, well-known register numbers and word/address types for the MIPS datapath.
// The register file, the muxes and the control unit all import this package.
package register_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam word_t     SP_INIT  = 32'h0000_03FC;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address select, $zero forcing and optional write forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs_i,
  input  logic                                wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W-1:0]                   wr_data_i,
  output logic [DATA_W-1:0]                   data_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_en_i && (wr_addr_i != ZERO_ADDR) && (wr_addr_i == addr_i);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  always_comb begin
    data_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit) data_o = wr_data_i;
`endif
    // $zero wins over everything, including forwarding.
    if (addr_i == ZERO_ADDR) data_o = '0;
  end

endmodule

// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational reads, one clocked write, $zero hardwired.
// Optional same-cycle write-to-read forwarding under macro REGFILE_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_03FC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(REG_SP);

  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_q;
  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (WriteReg != ZERO_ADDR)) regs_d[WriteReg] = WriteData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q          <= '0;
      regs_q[SP_ADDR] <= SP_INIT;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr_i    (ReadReg1),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (WriteReg),
    .wr_data_i (WriteData),
    .data_o    (ReadData1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr_i    (ReadReg2),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (WriteReg),
    .wr_data_i (WriteData),
    .data_o    (ReadData2)
  );

endmodule
